// File: rtl/vanilla_sb_retire_monitor_pkg.sv
// Shared types and class-encode helpers for the vanilla scoreboard retire monitor.
// Class index 0 is the lowest-priority-encoded bit of each scoreboard info entry.
package vanilla_sb_retire_monitor_pkg;

    localparam int reg_els_gp        = 32;
    localparam int reg_addr_width_gp = 5;
    localparam int cls_w_gp          = 3;
    localparam int ctr_width_gp      = 32;

    typedef enum logic [cls_w_gp-1:0] {
        e_int_idiv, e_int_dram_load, e_int_global_load,
        e_int_group_load, e_int_dram_amo, e_int_dram_seq_load
    } int_class_e;

    typedef enum logic [cls_w_gp-1:0] {
        e_fp_fdiv_fsqrt, e_fp_dram_load, e_fp_global_load,
        e_fp_group_load, e_fp_dram_seq_load
    } fp_class_e;

    typedef struct packed {
        logic dram_seq_load;
        logic dram_amo;
        logic group_load;
        logic global_load;
        logic dram_load;
        logic idiv;
    } isb_info_s;

    typedef struct packed {
        logic dram_seq_load;
        logic group_load;
        logic global_load;
        logic dram_load;
        logic fdiv_fsqrt;
    } fsb_info_s;

    // Output vectors flatten one of these per class, count in the MSBs.
    typedef struct packed {
        logic [ctr_width_gp-1:0] count;
        logic [ctr_width_gp-1:0] lat_sum;
        logic [ctr_width_gp-1:0] lat_max;
    } sb_stats_s;

    function automatic logic [cls_w_gp-1:0] lowest_set(input logic [7:0] bits);
        logic [cls_w_gp-1:0] idx;
        idx = '0;
        for (int k = 7; k >= 0; k--)
            if (bits[k]) idx = cls_w_gp'(k);
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [7:0] bits);
        return |(bits & (bits - 8'd1));
    endfunction

    function automatic int_class_e isb_encode(input isb_info_s info);
        return int_class_e'(lowest_set(8'(info)));
    endfunction

    function automatic fp_class_e fsb_encode(input fsb_info_s info);
        return fp_class_e'(lowest_set(8'(info)));
    endfunction

endpackage

// File: rtl/vanilla_sb_retire_file.sv
// One register file's entry tracker and per-class retire statistics.
// lat_max tracking is built only when VANILLA_SB_RETIRE_LAT_MAX_EN is defined.
module vanilla_sb_retire_file
    import vanilla_sb_retire_monitor_pkg::*;
#(
    parameter int class_els_p = 6,
    parameter int ctr_width_p = 32
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 en_i,
    input  logic                                 clear_stats_i,
    input  logic [ctr_width_p-1:0]               cycle_i,
    input  logic [reg_els_gp*class_els_p-1:0]    sb_i,
    input  logic                                 clear_i,
    input  logic [reg_addr_width_gp-1:0]         clear_id_i,
    output logic [class_els_p*3*ctr_width_p-1:0] stats_o,
    output logic                                 spurious_o,
    output logic                                 multi_o
);

    function automatic logic [ctr_width_p-1:0] sat_add(input logic [ctr_width_p-1:0] a,
                                                       input logic [ctr_width_p-1:0] b);
        logic [ctr_width_p:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ctr_width_p] ? '1 : s[ctr_width_p-1:0];
    endfunction

    logic [class_els_p-1:0] info [reg_els_gp];
    logic [reg_els_gp-1:0]  pending;
    logic                   multi_hit;

    logic [reg_els_gp-1:0]  tracked_r;
    logic [ctr_width_p-1:0] ts_r  [reg_els_gp];
    logic [cls_w_gp-1:0]    cls_r [reg_els_gp];

    logic                   clr_tracked, clr_pending, ret_vld;
    logic [ctr_width_p-1:0] ret_lat;
    logic [cls_w_gp-1:0]    ret_cls;

    always_comb begin
        pending   = '0;
        multi_hit = 1'b0;
        for (int i = 0; i < reg_els_gp; i++) begin
            info[i]    = sb_i[i*class_els_p +: class_els_p];
            pending[i] = |info[i];
            multi_hit  = multi_hit | multi_hot(8'(info[i]));
        end
    end

    assign multi_o = en_i & multi_hit;

    // An untracked but pending entry retires with zero latency and its live class.
    always_comb begin
        clr_tracked = tracked_r[clear_id_i];
        clr_pending = pending[clear_id_i];
        ret_vld     = en_i & clear_i & (clr_tracked | clr_pending);
        spurious_o  = en_i & clear_i & ~clr_tracked & ~clr_pending;
        ret_lat     = clr_tracked ? cycle_i - ts_r[clear_id_i] : '0;
        ret_cls     = clr_tracked ? cls_r[clear_id_i] : lowest_set(8'(info[clear_id_i]));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tracked_r <= '0;
            for (int i = 0; i < reg_els_gp; i++) begin
                ts_r[i]  <= '0;
                cls_r[i] <= '0;
            end
        end else if (en_i) begin
            for (int i = 0; i < reg_els_gp; i++) begin
                if (clear_i && clear_id_i == reg_addr_width_gp'(i)) begin
                    tracked_r[i] <= 1'b0;
                end else if (pending[i] && !tracked_r[i]) begin
                    tracked_r[i] <= 1'b1;
                    ts_r[i]      <= cycle_i;
                    cls_r[i]     <= lowest_set(8'(info[i]));
                end
            end
        end
    end

    // p0: retire event registered at the clear edge
    logic                   vld_p0;
    logic [ctr_width_p-1:0] lat_p0;
    logic [cls_w_gp-1:0]    cls_p0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_p0 <= 1'b0;
            lat_p0 <= '0;
            cls_p0 <= '0;
        end else begin
            vld_p0 <= ret_vld;
            lat_p0 <= ret_lat;
            cls_p0 <= ret_cls;
        end
    end

    // p1: per-class accumulators
    logic [ctr_width_p-1:0] count_r [class_els_p];
    logic [ctr_width_p-1:0] sum_r   [class_els_p];
    logic [ctr_width_p-1:0] lat_max [class_els_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i || clear_stats_i) begin
            for (int c = 0; c < class_els_p; c++) begin
                count_r[c] <= '0;
                sum_r[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < class_els_p; c++)
                if (vld_p0 && cls_p0 == cls_w_gp'(c)) begin
                    count_r[c] <= sat_add(count_r[c], ctr_width_p'(1));
                    sum_r[c]   <= sat_add(sum_r[c], lat_p0);
                end
        end
    end

`ifdef VANILLA_SB_RETIRE_LAT_MAX_EN
    logic [ctr_width_p-1:0] max_r [class_els_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i || clear_stats_i) begin
            for (int c = 0; c < class_els_p; c++) max_r[c] <= '0;
        end else begin
            for (int c = 0; c < class_els_p; c++)
                if (vld_p0 && cls_p0 == cls_w_gp'(c) && lat_p0 > max_r[c])
                    max_r[c] <= lat_p0;
        end
    end

    for (genvar c = 0; c < class_els_p; c++) begin : g_lat_max
        assign lat_max[c] = max_r[c];
    end
`else
    for (genvar c = 0; c < class_els_p; c++) begin : g_lat_max
        assign lat_max[c] = '0;
    end
`endif

    always_comb begin
        stats_o = '0;
        for (int c = 0; c < class_els_p; c++)
            stats_o[c*3*ctr_width_p +: 3*ctr_width_p] = {count_r[c], sum_r[c], lat_max[c]};
    end

endmodule

// File: rtl/vanilla_scoreboard_retire_monitor.sv
// Retire-end monitor: int and float trackers sharing one saturating cycle counter.
// Define VANILLA_SB_RETIRE_LAT_MAX_EN to build the per-class max-latency trackers.
module vanilla_scoreboard_retire_monitor
    import vanilla_sb_retire_monitor_pkg::*;
#(
    parameter int ctr_width_p     = 32,
    parameter int int_class_els_p = 6,
    parameter int fp_class_els_p  = 5
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic                                     en_i,
    input  logic                                     clear_stats_i,
    input  logic [reg_els_gp*int_class_els_p-1:0]    int_sb_i,
    input  logic [reg_els_gp*fp_class_els_p-1:0]     float_sb_i,
    input  logic                                     int_sb_clear_i,
    input  logic [reg_addr_width_gp-1:0]             int_sb_clear_id_i,
    input  logic                                     float_sb_clear_i,
    input  logic [reg_addr_width_gp-1:0]             float_sb_clear_id_i,
    output logic [int_class_els_p*3*ctr_width_p-1:0] int_stats_o,
    output logic [fp_class_els_p*3*ctr_width_p-1:0]  fp_stats_o,
    output logic                                     err_spurious_o,
    output logic                                     err_multi_o
);

    logic [ctr_width_p-1:0] cycle_r;
    logic                   int_spurious, int_multi, fp_spurious, fp_multi;
    logic                   err_spurious_r, err_multi_r;

    // Free-running regardless of en_i so latencies span disabled windows.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)            cycle_r <= '0;
        else if (cycle_r != '1)    cycle_r <= cycle_r + ctr_width_p'(1);
    end

    vanilla_sb_retire_file #(
        .class_els_p (int_class_els_p),
        .ctr_width_p (ctr_width_p)
    ) int_file (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .en_i          (en_i),
        .clear_stats_i (clear_stats_i),
        .cycle_i       (cycle_r),
        .sb_i          (int_sb_i),
        .clear_i       (int_sb_clear_i),
        .clear_id_i    (int_sb_clear_id_i),
        .stats_o       (int_stats_o),
        .spurious_o    (int_spurious),
        .multi_o       (int_multi)
    );

    vanilla_sb_retire_file #(
        .class_els_p (fp_class_els_p),
        .ctr_width_p (ctr_width_p)
    ) fp_file (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .en_i          (en_i),
        .clear_stats_i (clear_stats_i),
        .cycle_i       (cycle_r),
        .sb_i          (float_sb_i),
        .clear_i       (float_sb_clear_i),
        .clear_id_i    (float_sb_clear_id_i),
        .stats_o       (fp_stats_o),
        .spurious_o    (fp_spurious),
        .multi_o       (fp_multi)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i || clear_stats_i) begin
            err_spurious_r <= 1'b0;
            err_multi_r    <= 1'b0;
        end else begin
            err_spurious_r <= err_spurious_r | int_spurious | fp_spurious;
            err_multi_r    <= err_multi_r | int_multi | fp_multi;
        end
    end

    assign err_spurious_o = err_spurious_r;
    assign err_multi_o    = err_multi_r;

endmodule

// File: tb/tb_vanilla_scoreboard_retire_monitor.sv
// Bench for vanilla_scoreboard_retire_monitor: a 32-bit and a 4-bit instance share stimulus
// and are compared every cycle against a behavioural per-register / per-class model.
module tb_vanilla_scoreboard_retire_monitor;

    localparam int NR = 32;
`ifdef VANILLA_SB_RETIRE_LAT_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_n_i, en_i, clear_stats_i;
    logic [NR*6-1:0] int_sb;
    logic [NR*5-1:0] float_sb;
    logic int_clr, fp_clr;
    logic [4:0] int_id, fp_id;
    logic [6*96-1:0] int_st32;
    logic [5*96-1:0] fp_st32;
    logic [6*12-1:0] int_st4;
    logic [5*12-1:0] fp_st4;
    logic sp32, mu32, sp4, mu4;

    always #5 clk_i = ~clk_i;

    vanilla_scoreboard_retire_monitor #(.ctr_width_p(32), .int_class_els_p(6), .fp_class_els_p(5)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .clear_stats_i(clear_stats_i),
        .int_sb_i(int_sb), .float_sb_i(float_sb),
        .int_sb_clear_i(int_clr), .int_sb_clear_id_i(int_id),
        .float_sb_clear_i(fp_clr), .float_sb_clear_id_i(fp_id),
        .int_stats_o(int_st32), .fp_stats_o(fp_st32),
        .err_spurious_o(sp32), .err_multi_o(mu32));

    vanilla_scoreboard_retire_monitor #(.ctr_width_p(4), .int_class_els_p(6), .fp_class_els_p(5)) dut4 (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .clear_stats_i(clear_stats_i),
        .int_sb_i(int_sb), .float_sb_i(float_sb),
        .int_sb_clear_i(int_clr), .int_sb_clear_id_i(int_id),
        .float_sb_clear_i(fp_clr), .float_sb_clear_id_i(fp_id),
        .int_stats_o(int_st4), .fp_stats_o(fp_st4),
        .err_spurious_o(sp4), .err_multi_o(mu4));

    int n_chk = 0;
    int n_err = 0;

    // stimulus shadow: class bits per register, per file (0 = int, 1 = float)
    int unsigned sbv [2][NR];
    bit          clr_v [2];
    int          clr_id [2];

    // model state, first index: 0 = 32-bit instance, 1 = 4-bit instance
    longint unsigned m_cycle [2];
    bit              m_trk [2][2][NR];
    longint unsigned m_ts  [2][2][NR];
    int              m_cls [2][2][NR];
    longint unsigned m_cnt [2][2][6];
    longint unsigned m_sum [2][2][6];
    longint unsigned m_max [2][2][6];
    bit              m_pv  [2][2];
    int              m_pcls [2][2];
    longint unsigned m_plat [2][2];
    bit              m_sp [2];
    bit              m_mu [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned sat(input int w, input longint unsigned v);
        longint unsigned lim;
        lim = (w != 0) ? 64'd15 : 64'hFFFF_FFFF;
        return (v > lim) ? lim : v;
    endfunction

    function automatic int lowest(input int unsigned v);
        for (int k = 0; k < 8; k++)
            if (v[k]) return k;
        return 0;
    endfunction

    function automatic longint unsigned mx(input longint unsigned v);
        return MAX_EN ? v : 64'd0;
    endfunction

    function automatic logic [575:0] svec(input int w, input int f);
        if (w == 0) return (f == 0) ? 576'(int_st32) : 576'(fp_st32);
        return (f == 0) ? 576'(int_st4) : 576'(fp_st4);
    endfunction

    // k: 2 = count, 1 = lat_sum, 0 = lat_max
    function automatic logic [63:0] fld(input logic [575:0] v, input int width, input int c, input int k);
        logic [575:0] s;
        s = v >> (c*3*width + k*width);
        return s[63:0] & ((64'd1 << width) - 64'd1);
    endfunction

    task automatic model_reset();
        m_cycle = '{default: '0};
        m_trk   = '{default: '0};
        m_ts    = '{default: '0};
        m_cls   = '{default: 0};
        m_cnt   = '{default: '0};
        m_sum   = '{default: '0};
        m_max   = '{default: '0};
        m_pv    = '{default: '0};
        m_pcls  = '{default: 0};
        m_plat  = '{default: '0};
        m_sp    = '{default: '0};
        m_mu    = '{default: '0};
    endtask

    task automatic model_step(input int w);
        bit sp, mu, pv;
        int pc, nc, id, c;
        longint unsigned pl;
        sp = 0; mu = 0;
        for (int f = 0; f < 2; f++) begin
            nc = (f != 0) ? 5 : 6;
            if (clear_stats_i) begin
                for (int k = 0; k < nc; k++) begin
                    m_cnt[w][f][k] = 0; m_sum[w][f][k] = 0; m_max[w][f][k] = 0;
                end
            end else if (m_pv[w][f]) begin
                c = m_pcls[w][f];
                m_cnt[w][f][c] = sat(w, m_cnt[w][f][c] + 1);
                m_sum[w][f][c] = sat(w, m_sum[w][f][c] + m_plat[w][f]);
                if (m_plat[w][f] > m_max[w][f][c]) m_max[w][f][c] = m_plat[w][f];
            end
            pv = 0; pc = 0; pl = 0;
            if (en_i && clr_v[f]) begin
                id = clr_id[f];
                if (m_trk[w][f][id]) begin
                    pv = 1; pl = m_cycle[w] - m_ts[w][f][id]; pc = m_cls[w][f][id];
                end else if (sbv[f][id] != 0) begin
                    pv = 1; pc = lowest(sbv[f][id]);
                end else begin
                    sp = 1;
                end
            end
            if (en_i) begin
                for (int i = 0; i < NR; i++) begin
                    if ($countones(sbv[f][i]) > 1) mu = 1;
                    if (clr_v[f] && clr_id[f] == i) begin
                        m_trk[w][f][i] = 0;
                    end else if (sbv[f][i] != 0 && !m_trk[w][f][i]) begin
                        m_trk[w][f][i] = 1;
                        m_ts[w][f][i]  = m_cycle[w];
                        m_cls[w][f][i] = lowest(sbv[f][i]);
                    end
                end
            end
            m_pv[w][f] = pv; m_pcls[w][f] = pc; m_plat[w][f] = pl;
        end
        if (clear_stats_i) begin
            m_sp[w] = 0; m_mu[w] = 0;
        end else begin
            m_sp[w] = m_sp[w] | sp; m_mu[w] = m_mu[w] | mu;
        end
        m_cycle[w] = sat(w, m_cycle[w] + 1);
    endtask

    task automatic compare_all();
        int width;
        for (int w = 0; w < 2; w++) begin
            width = (w != 0) ? 4 : 32;
            for (int f = 0; f < 2; f++)
                for (int c = 0; c < ((f != 0) ? 5 : 6); c++) begin
                    check_eq($sformatf("w%0d_f%0d_c%0d_count", width, f, c), fld(svec(w, f), width, c, 2), m_cnt[w][f][c]);
                    check_eq($sformatf("w%0d_f%0d_c%0d_sum", width, f, c), fld(svec(w, f), width, c, 1), m_sum[w][f][c]);
                    check_eq($sformatf("w%0d_f%0d_c%0d_max", width, f, c), fld(svec(w, f), width, c, 0), mx(m_max[w][f][c]));
                end
        end
        check_eq("err_spurious_w32", {63'd0, sp32}, {63'd0, m_sp[0]});
        check_eq("err_multi_w32",    {63'd0, mu32}, {63'd0, m_mu[0]});
        check_eq("err_spurious_w4",  {63'd0, sp4},  {63'd0, m_sp[1]});
        check_eq("err_multi_w4",     {63'd0, mu4},  {63'd0, m_mu[1]});
    endtask

    task automatic tick();
        for (int i = 0; i < NR; i++) begin
            int_sb[i*6 +: 6]   = sbv[0][i][5:0];
            float_sb[i*5 +: 5] = sbv[1][i][4:0];
        end
        int_clr = clr_v[0]; int_id = 5'(clr_id[0]);
        fp_clr  = clr_v[1]; fp_id  = 5'(clr_id[1]);
        @(posedge clk_i);
        if (!reset_n_i) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all();
    endtask

    task automatic clear_stim();
        sbv = '{default: 0};
        clr_v = '{default: 0};
        clr_id = '{default: 0};
    endtask

    int c;
    int k;

    initial begin
        reset_n_i = 1'b0; en_i = 1'b0; clear_stats_i = 1'b0;
        clear_stim();
        model_reset();
        #2;
        compare_all();
        tick();
        tick();
        reset_n_i = 1'b1;
        en_i = 1'b1;

        // directed: single load, set/clear overlap, spurious, multi-class, start+clear same cycle
        while (m_cycle[0] <= 64) begin
            c = int'(m_cycle[0]);
            sbv[0][5] = (c >= 10 && c < 42) ? 2 : 0;
            sbv[1][3] = (c >= 12 && c < 30) ? 16 : 0;
            sbv[0][2] = (c >= 50 && c < 60) ? 17 : 0;
            sbv[0][9] = (c == 62) ? 4 : 0;
            clr_v[0]  = (c == 42 || c == 44 || c == 60 || c == 62);
            clr_id[0] = (c == 42) ? 5 : (c == 44) ? 7 : (c == 60) ? 2 : 9;
            clr_v[1]  = (c == 20 || c == 30);
            clr_id[1] = 3;
            clear_stats_i = (c == 48);
            tick();
            case (c)
                21: begin
                    check_eq("fp_seq_first_count", fld(fp_st32, 32, 4, 2), 1);
                    check_eq("fp_seq_first_sum",   fld(fp_st32, 32, 4, 1), 8);
                end
                31: begin
                    check_eq("fp_seq_count", fld(fp_st32, 32, 4, 2), 2);
                    check_eq("fp_seq_sum",   fld(fp_st32, 32, 4, 1), 17);
                    check_eq("fp_seq_max",   fld(fp_st32, 32, 4, 0), mx(9));
                end
                42: check_eq("single_not_yet", fld(int_st32, 32, 1, 2), 0);
                43: begin
                    check_eq("single_count", fld(int_st32, 32, 1, 2), 1);
                    check_eq("single_sum",   fld(int_st32, 32, 1, 1), 32);
                    check_eq("single_max",   fld(int_st32, 32, 1, 0), mx(32));
                end
                45: begin
                    check_eq("spurious_flag",  {63'd0, sp32}, 1);
                    check_eq("spurious_count", fld(int_st32, 32, 1, 2), 1);
                end
                48: begin
                    check_eq("clear_stats_err",   {63'd0, sp32}, 0);
                    check_eq("clear_stats_count", fld(int_st32, 32, 1, 2), 0);
                end
                50: check_eq("multi_flag", {63'd0, mu32}, 1);
                61: begin
                    check_eq("multi_idiv_count", fld(int_st32, 32, 0, 2), 1);
                    check_eq("multi_idiv_sum",   fld(int_st32, 32, 0, 1), 10);
                    check_eq("multi_amo_count",  fld(int_st32, 32, 4, 2), 0);
                end
                63: begin
                    check_eq("same_cycle_count", fld(int_st32, 32, 2, 2), 1);
                    check_eq("same_cycle_sum",   fld(int_st32, 32, 2, 1), 0);
                end
                default: ;
            endcase
        end
        clear_stats_i = 1'b0;

        // asynchronous reset mid-cycle, then saturation run
        #3 reset_n_i = 1'b0;
        #1;
        clear_stim();
        model_reset();
        compare_all();
        tick();
        tick();
        reset_n_i = 1'b1;
        while (m_cycle[0] < 24) begin
            c = int'(m_cycle[0]);
            for (int i = 0; i < 20; i++) sbv[0][i] = (c < i + 1) ? 1 : 0;
            clr_v[0]  = (c >= 1 && c <= 20);
            clr_id[0] = (c >= 1) ? c - 1 : 0;
            tick();
        end
        check_eq("sat_w4_count",  fld(int_st4, 4, 0, 2), 15);
        check_eq("sat_w4_sum",    fld(int_st4, 4, 0, 1), 15);
        check_eq("sat_w4_max",    fld(int_st4, 4, 0, 0), mx(15));
        check_eq("sat_w32_count", fld(int_st32, 32, 0, 2), 20);
        check_eq("sat_w32_sum",   fld(int_st32, 32, 0, 1), 210);
        check_eq("sat_w32_max",   fld(int_st32, 32, 0, 0), mx(20));

        // randomized traffic
        clear_stim();
        for (int n = 0; n < 2000; n++) begin
            en_i = ($urandom_range(0, 7) != 0);
            clear_stats_i = ($urandom_range(0, 63) == 0);
            for (int f = 0; f < 2; f++) begin
                for (int i = 0; i < NR; i++) begin
                    if (sbv[f][i] == 0) begin
                        if ($urandom_range(0, 15) == 0) begin
                            k = $urandom_range(0, (f != 0) ? 4 : 5);
                            sbv[f][i] = 32'd1 << k;
                            if ($urandom_range(0, 7) == 0) begin
                                k = $urandom_range(0, (f != 0) ? 4 : 5);
                                sbv[f][i] = sbv[f][i] | (32'd1 << k);
                            end
                        end
                    end else if ($urandom_range(0, 15) == 0) begin
                        sbv[f][i] = 0;
                    end
                end
                clr_v[f]  = ($urandom_range(0, 2) == 0);
                clr_id[f] = $urandom_range(0, NR - 1);
                if (clr_v[f] && $urandom_range(0, 1) == 1) sbv[f][clr_id[f]] = 0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
